ams_pwm_gen: RTL
================

AMS_PWM_GEN -- requirements
Module: ams_pwm_gen

Interface
REQ-001 SHALL have parameter CCW, default 24, as the configuration word width.
REQ-002 SHALL have parameter CNTW, default 8, as the PWM period counter width (256 cycles per PWM period).
REQ-003 SHALL have parameter SEQW, default 16, as the dither sequence length in PWM periods.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock (250 MHz DAC clock).
REQ-005 SHALL have port rstn_i, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port cfg_i, input, CCW bits: configuration word; [23:16] is the base duty and [15:0] is the dither sequence.
REQ-007 SHALL have port pwm_o, output, 1 bit: the PWM DAC output bit.
REQ-008 SHALL have port frame_o, output, 1 bit: one-cycle strobe at dither-frame start, aligned with pwm_o.
REQ-009 SHALL have port cfg_act_o, output, CCW bits: the configuration word currently applied, for bus readback.

Function
REQ-010 SHALL keep an 8-bit period counter cnt that increments every clk_i cycle, with wrap 255->0.
REQ-011 SHALL keep a 4-bit period index idx that increments when cnt wraps, with wrap 15->0; one frame is 4096 cycles.
REQ-012 SHALL load cfg_i into the shadow register cfg_act only in the cycle where cnt==255 and idx==15, so the new word takes effect at the next frame start.
REQ-013 SHALL ignore any other change of cfg_i, including mid-frame and mid-period changes.
REQ-014 SHALL compute the period threshold thr = cfg_act[23:16] + cfg_act[idx] as a 9-bit zero-extended value, range 0..256.
REQ-015 SHALL register pwm_o <= ({1'b0,cnt} < thr), giving a latency of 1 cycle from the counter state.
REQ-016 SHALL produce an output that is high for exactly thr cycles per period, starting at the period's first cycle, so that thr=0 gives constant low and thr=256 gives constant high with no glitch across the period boundary.
REQ-017 SHALL honour all 16 sequence bits, including bit 15, without forcing any bit to 0.
REQ-018 SHALL produce a high-cycle count per frame equal to 16*duty + popcount(cfg_act[15:0]).
REQ-019 SHALL register frame_o <= (cnt==0 && idx==0), so that frame_o is high in the same cycle as pwm_o for the first cycle of the frame.
REQ-020 SHALL drive cfg_act_o directly from cfg_act.
REQ-021 SHALL use only unsigned arithmetic; sign conversion is the producer's responsibility.

Reset
REQ-022 SHALL, while rstn_i is low, set cnt, idx, cfg_act, pwm_o, frame_o and cfg_act_o to 0 asynchronously.
REQ-023 SHALL start the first frame at cnt=0, idx=0 on the first clock after reset release, using cfg_act=0, so that pwm_o stays low for 4096 cycles.
REQ-024 SHALL load cfg_i for the first time at the end of that first frame.
REQ-025 SHALL, on reset asserted mid-period, force pwm_o low immediately, without waiting for a clock edge.

Structure
REQ-026 SHALL take CCW, CNTW, SEQW and the duty field positions (DUTY_MSB=23, DUTY_LSB=16, SEQ_MSB=15) from a shared package ams_pkg, also used by the cfg encoder.
REQ-027 SHALL be implemented as a single flat module with no sub-module, instantiated once per PWM channel by the top level.

Verification
REQ-028 SHALL verify: cfg_i=24'h000000 held -> pwm_o constantly 0; frame_o pulses every 4096 cycles.
REQ-029 SHALL verify: cfg_i=24'h800000 -> from frame 2 onward, pwm_o is high for 128 cycles then low for 128 cycles in every period; 2048 high cycles per frame.
REQ-030 SHALL verify: cfg_i=24'hFFFFFF -> thr=256 in every period; pwm_o constantly high from frame 2, with no low cycle at period boundaries.
REQ-031 SHALL verify: cfg_i=24'h405555 -> periods with even idx give 65 high cycles, periods with odd idx give 64; 1032 high cycles per frame.
REQ-032 SHALL verify: cfg_i switched from 24'h100000 to 24'h200000 at idx=7 -> remaining periods keep 16 high cycles; the next frame gives 32; a switch applied exactly at (cnt=255, idx=15) takes effect in the immediately following frame.
REQ-033 SHALL verify: rstn_i pulsed low for 3 cycles at cnt=50, idx=9 during a pwm_o-high phase -> pwm_o, frame_o and cfg_act_o read 0 before the next clock edge; after release, the counters restart at 0 and pwm_o is low for 4096 cycles.

Source files
------------

// File: rtl/ams_pkg.sv
// Shared constants for the AMS PWM DAC channel and its configuration encoder.
// The configuration word holds the base duty and a per-period dither sequence.
package ams_pkg;

  localparam int unsigned CCW  = 24;
  localparam int unsigned CNTW = 8;
  localparam int unsigned SEQW = 16;

  localparam int unsigned DUTY_MSB = 23;
  localparam int unsigned DUTY_LSB = 16;
  localparam int unsigned SEQ_MSB  = 15;

endpackage

// File: rtl/ams_pwm_gen.sv
// Dithered PWM DAC channel: 16 periods of 256 cycles form one frame.
// Each period adds one dither bit to the base duty; configuration is shadowed per frame.
module ams_pwm_gen
  import ams_pkg::*;
#(
  parameter int unsigned CCW  = ams_pkg::CCW,
  parameter int unsigned CNTW = ams_pkg::CNTW,
  parameter int unsigned SEQW = ams_pkg::SEQW
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  input  logic [CCW-1:0] cfg_i,
  output logic           pwm_o,
  output logic           frame_o,
  output logic [CCW-1:0] cfg_act_o
);

  localparam int unsigned IdxW = $clog2(SEQW);

  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [CCW-1:0]  cfg_act_q, cfg_act_d;
  logic            pwm_q, pwm_d;
  logic            frame_q, frame_d;

  logic [CNTW-1:0] duty;
  logic [SEQW-1:0] seq;
  logic [CNTW:0]   thr;
  logic            cnt_wrap;
  logic            frame_end;

  always_comb begin
    duty      = cfg_act_q[DUTY_MSB:DUTY_LSB];
    seq       = cfg_act_q[SEQ_MSB -: SEQW];
    // 9-bit threshold so duty 255 plus a dither bit reaches 256 (constant high).
    thr       = {1'b0, duty} + {{CNTW{1'b0}}, seq[idx_q]};
    cnt_wrap  = (cnt_q == '1);
    frame_end = cnt_wrap && (idx_q == '1);

    cnt_d     = cnt_q + CNTW'(1);
    idx_d     = cnt_wrap ? idx_q + IdxW'(1) : idx_q;
    cfg_act_d = frame_end ? cfg_i : cfg_act_q;
    pwm_d     = ({1'b0, cnt_q} < thr);
    frame_d   = (cnt_q == '0) && (idx_q == '0);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      cfg_act_q <= '0;
      pwm_q     <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      cfg_act_q <= cfg_act_d;
      pwm_q     <= pwm_d;
      frame_q   <= frame_d;
    end
  end

  assign pwm_o     = pwm_q;
  assign frame_o   = frame_q;
  assign cfg_act_o = cfg_act_q;

endmodule
